// File: rtl/sdrd_fat32pack_pkg.sv
// Shared constants and state type for the SD-read byte-to-word packer
// that feeds the FAT32 sector buffer.
package sdrd_fat32pack_pkg;

  localparam int unsigned SECTOR_BYTES_DEF = 512;
  localparam int unsigned FAT_WORD_W       = 256;
  localparam int unsigned FAT_WORD_BYTES   = FAT_WORD_W / 8;
  localparam int unsigned WORDS_PER_SECTOR = SECTOR_BYTES_DEF / FAT_WORD_BYTES;

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_PEND = 1'b1
  } pack_state_e;

endpackage

// File: rtl/sdrd_fat32pack_if.sv
// Byte-in / word-out bundle between the SD reader, the packer and the
// FAT32 buffer FIFO plus its control logic.
interface sdrd_fat32pack_if;
  import sdrd_fat32pack_pkg::*;

  logic [7:0]            DIN;
  logic                  DIN_VALID;
  logic                  DIN_READY;
  logic                  ABORT;
  logic                  FULL;
  logic                  WR;
  logic [FAT_WORD_W-1:0] OUTPUT;
  logic                  SECTOR_DONE;
  logic [3:0]            WORD_CNT;
  logic [31:0]           SECTOR_CNT;

  modport slave (
    input  DIN, DIN_VALID, ABORT, FULL,
    output DIN_READY, WR, OUTPUT, SECTOR_DONE, WORD_CNT, SECTOR_CNT
  );

  modport master (
    output DIN, DIN_VALID, ABORT, FULL,
    input  DIN_READY, WR, OUTPUT, SECTOR_DONE, WORD_CNT, SECTOR_CNT
  );
endinterface

// File: rtl/sdrd_fat32pack.sv
// Packs 32 SD bytes little-endian into one 256-bit FAT32 buffer word,
// holds it until the FIFO has room, and tracks 512-byte sector boundaries.
module sdrd_fat32pack
  import sdrd_fat32pack_pkg::*;
#(
  parameter int unsigned SECTOR_BYTES = SECTOR_BYTES_DEF
) (
  input  logic             CLK,
  input  logic             RSTS,
  sdrd_fat32pack_if.slave  bus
);

  localparam logic [3:0] LAST_WORD = 4'(SECTOR_BYTES / FAT_WORD_BYTES - 1);

  pack_state_e           state_q, state_d;
  logic [4:0]            bcnt_q, bcnt_d;
  logic [FAT_WORD_W-1:0] data_q, data_d;
  logic [3:0]            word_cnt_q, word_cnt_d;
  logic [31:0]           sector_cnt_q, sector_cnt_d;
  logic                  sdone_q, sdone_d;
  logic                  din_ready;
  logic                  wr;

  always_ff @(posedge CLK or posedge RSTS) begin
    if (RSTS) begin
      state_q      <= ST_FILL;
      bcnt_q       <= '0;
      data_q       <= '0;
      word_cnt_q   <= '0;
      sector_cnt_q <= '0;
      sdone_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      bcnt_q       <= bcnt_d;
      data_q       <= data_d;
      word_cnt_q   <= word_cnt_d;
      sector_cnt_q <= sector_cnt_d;
      sdone_q      <= sdone_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    bcnt_d       = bcnt_q;
    data_d       = data_q;
    word_cnt_d   = word_cnt_q;
    sector_cnt_d = sector_cnt_q;
    sdone_d      = 1'b0;
    din_ready    = 1'b0;
    wr           = 1'b0;

    // ABORT also masks DIN_READY so a byte offered in that cycle is never handshaken.
    if (bus.ABORT) begin
      state_d    = ST_FILL;
      bcnt_d     = '0;
      word_cnt_d = '0;
      data_d     = '0;
    end else begin
      case (state_q)
        ST_FILL: begin
          din_ready = 1'b1;
          if (bus.DIN_VALID) begin
            data_d[{bcnt_q, 3'b000} +: 8] = bus.DIN;
            bcnt_d = bcnt_q + 5'd1;
            if (bcnt_q == 5'd31) begin
              state_d = ST_PEND;
            end
          end
        end
        ST_PEND: begin
          if (!bus.FULL) begin
            wr      = 1'b1;
            state_d = ST_FILL;
            if (word_cnt_q == LAST_WORD) begin
              word_cnt_d   = '0;
              sector_cnt_d = sector_cnt_q + 32'd1;
              sdone_d      = 1'b1;
            end else begin
              word_cnt_d = word_cnt_q + 4'd1;
            end
          end
        end
        default: state_d = ST_FILL;
      endcase
    end
  end

  assign bus.DIN_READY   = din_ready;
  assign bus.WR          = wr;
  assign bus.OUTPUT      = data_q;
  assign bus.SECTOR_DONE = sdone_q;
  assign bus.WORD_CNT    = word_cnt_q;
  assign bus.SECTOR_CNT  = sector_cnt_q;

endmodule

// File: tb/tb_sdrd_fat32pack.sv
// Self-checking bench for sdrd_fat32pack: byte-list model with a word
// scoreboard checked every cycle, plus literal spot checks per scenario.
module tb_sdrd_fat32pack;
  import sdrd_fat32pack_pkg::*;

  logic CLK = 1'b0;
  logic RSTS = 1'b1;
  always #5 CLK = ~CLK;

  sdrd_fat32pack_if bus ();

  sdrd_fat32pack #(.SECTOR_BYTES(512)) dut (
    .CLK  (CLK),
    .RSTS (RSTS),
    .bus  (bus)
  );

  int unsigned tot_cnt  = 0;
  int unsigned pass_cnt = 0;
  int unsigned cyc      = 0;
  int unsigned wr_total = 0;
  int unsigned wr_cyc[$];

  // model: bytes of the word being assembled, and all bytes not yet written out
  logic [7:0]  m_cur [32];
  logic [7:0]  sb [$];
  int unsigned m_nb;
  bit          m_pend;
  int unsigned m_wcnt;
  logic [31:0] m_scnt;
  bit          m_done;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic m_reset();
    for (int k = 0; k < 32; k++) m_cur[k] = 8'h00;
    sb.delete();
    m_nb = 0; m_pend = 0; m_wcnt = 0; m_scnt = 0; m_done = 0;
  endtask

  function automatic logic [255:0] cur_word();
    logic [255:0] w;
    for (int k = 0; k < 32; k++) w[8*k +: 8] = m_cur[k];
    return w;
  endfunction

  always @(negedge CLK) begin
    bit exp_rdy, exp_wr, nxt_done;
    logic [255:0] w;
    cyc++;
    if (RSTS) m_reset();
    exp_rdy = !m_pend && !bus.ABORT;
    exp_wr  = m_pend && !bus.FULL && !bus.ABORT;
    chk("din_ready",   bus.DIN_READY,   exp_rdy);
    chk("wr",          bus.WR,          exp_wr);
    chk("output",      bus.OUTPUT,      cur_word());
    chk("sector_done", bus.SECTOR_DONE, m_done);
    chk("word_cnt",    bus.WORD_CNT,    m_wcnt);
    chk("sector_cnt",  bus.SECTOR_CNT,  m_scnt);
    if (bus.WR) begin
      wr_total++;
      wr_cyc.push_back(cyc);
    end
    nxt_done = 0;
    if (!RSTS) begin
      if (bus.ABORT) begin
        for (int k = 0; k < 32; k++) m_cur[k] = 8'h00;
        sb.delete();
        m_nb = 0; m_pend = 0; m_wcnt = 0;
      end else if (exp_wr) begin
        if (sb.size() < 32) begin
          chk("sb_underflow", sb.size(), 32);
        end else begin
          for (int k = 0; k < 32; k++) w[8*k +: 8] = sb.pop_front();
          chk("sb_word", bus.OUTPUT, w);
        end
        m_pend = 0;
        if (m_wcnt == WORDS_PER_SECTOR - 1) begin
          m_wcnt = 0; m_scnt = m_scnt + 1; nxt_done = 1;
        end else begin
          m_wcnt++;
        end
      end else if (bus.DIN_VALID && exp_rdy) begin
        m_cur[m_nb] = bus.DIN;
        sb.push_back(bus.DIN);
        m_nb++;
        if (m_nb == 32) begin m_nb = 0; m_pend = 1; end
      end
    end
    m_done = nxt_done;
  end

  task automatic send(input logic [7:0] b);
    int unsigned n = 0;
    logic rdy;
    bus.DIN = b;
    bus.DIN_VALID = 1'b1;
    do begin
      @(negedge CLK);
      rdy = bus.DIN_READY;
      @(posedge CLK);
      #1;
      n++;
    end while (!rdy && n < 2000);
    if (!rdy) chk("send_timeout", 1'b0, 1'b1);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, got %0d/%0d checks passed", pass_cnt, tot_cnt);
    $fatal(1);
  end

  initial begin
    int unsigned base;
    bit done_flag;
    bus.DIN = 8'h00; bus.DIN_VALID = 1'b0; bus.ABORT = 1'b0; bus.FULL = 1'b0;
    repeat (3) @(negedge CLK);
    chk("rst_output", bus.OUTPUT, '0);
    chk("rst_ready", bus.DIN_READY, 1'b1);
    tick();
    RSTS = 1'b0;

    // one word 0x00..0x1F, back to back
    for (int i = 0; i < 32; i++) send(8'(i));
    bus.DIN_VALID = 1'b0;
    @(negedge CLK);
    chk("t1_wr", bus.WR, 1'b1);
    chk("t1_ready_low", bus.DIN_READY, 1'b0);
    chk("t1_word", bus.OUTPUT,
        256'h1f1e1d1c1b1a191817161514131211100f0e0d0c0b0a09080706050403020100);
    @(negedge CLK);
    chk("t1_wr_off", bus.WR, 1'b0);
    chk("t1_ready_back", bus.DIN_READY, 1'b1);
    chk("t1_word_cnt", bus.WORD_CNT, 4'd1);

    // asynchronous reset, then one full sector continuous
    tick();
    RSTS = 1'b1;
    @(negedge CLK);
    chk("t2_rst_word_cnt", bus.WORD_CNT, 4'd0);
    tick();
    RSTS = 1'b0;
    wr_cyc.delete();
    for (int i = 0; i < 512; i++) send(8'((i * 13 + 5) & 255));
    bus.DIN_VALID = 1'b0;
    @(negedge CLK);
    chk("t2_last_wr", bus.WR, 1'b1);
    @(negedge CLK);
    chk("t2_sector_done", bus.SECTOR_DONE, 1'b1);
    chk("t2_word_cnt", bus.WORD_CNT, 4'd0);
    chk("t2_sector_cnt", bus.SECTOR_CNT, 32'd1);
    @(negedge CLK);
    chk("t2_done_once", bus.SECTOR_DONE, 1'b0);
    chk("t2_wr_count", wr_cyc.size(), 16);
    for (int i = 1; i < wr_cyc.size(); i++) chk("t2_wr_spacing", wr_cyc[i] - wr_cyc[i-1], 33);

    // FULL held across word completion
    tick();
    bus.FULL = 1'b1;
    for (int i = 0; i < 32; i++) send(8'(8'h40 + i));
    bus.DIN_VALID = 1'b0;
    base = wr_total;
    repeat (50) @(negedge CLK);
    chk("t3_no_wr", wr_total, base);
    chk("t3_ready_low", bus.DIN_READY, 1'b0);
    chk("t3_word_held", bus.OUTPUT,
        256'h5f5e5d5c5b5a595857565554535251504f4e4d4c4b4a49484746454443424140);
    tick();
    bus.FULL = 1'b0;
    @(negedge CLK);
    chk("t3_wr", bus.WR, 1'b1);
    @(negedge CLK);
    chk("t3_ready_back", bus.DIN_READY, 1'b1);
    chk("t3_word_cnt", bus.WORD_CNT, 4'd1);

    // ABORT mid-word, with a byte offered in the ABORT cycle
    tick();
    for (int i = 0; i < 17; i++) send(8'(8'h50 + i));
    bus.DIN = 8'hEE; bus.DIN_VALID = 1'b1; bus.ABORT = 1'b1;
    @(negedge CLK);
    chk("t4_abort_ready", bus.DIN_READY, 1'b0);
    tick();
    bus.ABORT = 1'b0; bus.DIN_VALID = 1'b0;
    @(negedge CLK);
    chk("t4_cleared", bus.OUTPUT, '0);
    chk("t4_word_cnt0", bus.WORD_CNT, 4'd0);
    tick();
    for (int i = 0; i < 32; i++) send(8'(8'hA0 + i));
    bus.DIN_VALID = 1'b0;
    @(negedge CLK);
    chk("t4_wr", bus.WR, 1'b1);
    chk("t4_word", bus.OUTPUT,
        256'hbfbebdbcbbbab9b8b7b6b5b4b3b2b1b0afaeadacabaaa9a8a7a6a5a4a3a2a1a0);
    @(negedge CLK);
    chk("t4_word_cnt1", bus.WORD_CNT, 4'd1);

    // ABORT while held in PEND by FULL
    tick();
    bus.FULL = 1'b1;
    for (int i = 0; i < 32; i++) send(8'(8'h60 + i));
    bus.DIN_VALID = 1'b0;
    base = wr_total;
    repeat (5) tick();
    bus.ABORT = 1'b1;
    tick();
    bus.ABORT = 1'b0;
    bus.FULL = 1'b0;
    repeat (40) @(negedge CLK);
    chk("t5_no_wr", wr_total, base);
    chk("t5_sector_cnt", bus.SECTOR_CNT, 32'd1);
    chk("t5_word_cnt", bus.WORD_CNT, 4'd0);
    chk("t5_ready", bus.DIN_READY, 1'b1);

    // 64 sectors with random DIN_VALID gaps and random FULL
    tick();
    base = wr_total;
    done_flag = 0;
    fork
      begin
        for (int i = 0; i < 64 * 512; i++) begin
          if ($urandom_range(0, 3) == 0) begin
            bus.DIN_VALID = 1'b0;
            tick();
          end
          send(8'((i * 7 + i / 256) & 255));
        end
        bus.DIN_VALID = 1'b0;
        done_flag = 1;
      end
      begin
        while (!done_flag) begin
          bus.FULL = ($urandom_range(0, 3) == 0);
          tick();
        end
        bus.FULL = 1'b0;
      end
    join
    for (int n = 0; n < 100 && wr_total - base < 1024; n++) @(negedge CLK);
    @(negedge CLK);
    chk("t6_wr_count", wr_total - base, 1024);
    chk("t6_sector_cnt", bus.SECTOR_CNT, 32'd65);
    chk("t6_word_cnt", bus.WORD_CNT, 4'd0);
    chk("t6_sb_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule

// File: doc/sdrd_fat32pack.md
# sdrd_fat32pack

Byte-to-word packer that sits directly upstream of the FAT32 sector buffer in the SD read path. It accepts the 8-bit data stream from the SD card reader, assembles 32 consecutive bytes into one 256-bit word, and writes each word into the FAT32 buffer FIFO, honouring its FULL flag. It tracks the 512-byte sector boundary (16 words) and flags each completed sector to the FAT32 control logic.

## Interface
- SECTOR_BYTES, 512: bytes per SD sector; must be a multiple of 32.
- WORD_W, 256: output word width; fixed at 32 bytes.

- CLK  in  1  system clock; all logic on rising edge.
- RSTS  in  1  reset; asynchronous, active-high.
- DIN  in  8  byte from SD card reader.
- DIN_VALID  in  1  DIN holds a valid byte this cycle.
- DIN_READY  out  1  packer accepts DIN this cycle.
- ABORT  in  1  synchronous discard of partial word and sector position.
- FULL  in  1  FAT32 buffer FIFO full flag.
- WR  out  1  write strobe to FAT32 buffer FIFO.
- OUTPUT  out  256  word to FAT32 buffer FIFO input.
- SECTOR_DONE  out  1  one-cycle pulse when the last word of a sector is written.
- WORD_CNT  out  4  words of the current sector already written (0..15).
- SECTOR_CNT  out  32  completed sectors since reset; wraps.

## Operation
- Byte accepted when DIN_VALID && DIN_READY.
- Packing little-endian: byte k of a word (k = 0..31, arrival order) lands in OUTPUT[8k+7:8k].
- Byte counter BCNT (5 bits) increments per accepted byte; the accept with BCNT==31 completes the word; BCNT wraps to 0.
- States:
  - FILL: DIN_READY=1. On accept with BCNT==31 -> PEND.
  - PEND: DIN_READY=0; OUTPUT stable. WR = !FULL (combinational). When WR=1 -> FILL next cycle.
- WR is never asserted while FULL=1; the word is held in PEND indefinitely until FULL drops.
- On each write: WORD_CNT increments; if WORD_CNT==SECTOR_BYTES/32-1, WORD_CNT wraps to 0, SECTOR_DONE pulses in the cycle after WR, SECTOR_CNT increments (modulo 2^32).
- ABORT (highest priority after reset): next cycle state=FILL, BCNT=0, WORD_CNT=0, any pending word dropped (WR is forced 0 in the ABORT cycle), OUTPUT cleared to 0. SECTOR_CNT unaffected. A byte presented in the ABORT cycle is not accepted.
- OUTPUT bytes not yet written in a partially filled word are don't-care to the consumer; implementation holds stale data.

## Timing
- Reset values: state FILL, DIN_READY=1, WR=0, OUTPUT=0, SECTOR_DONE=0, WORD_CNT=0, SECTOR_CNT=0, BCNT=0.
- Latency: 32nd byte accepted at cycle n -> WR=1 at cycle n+1 if FULL=0.
- Throughput: 32 bytes per 33 cycles with continuous DIN_VALID and FULL=0 (one bubble per word in PEND).
- FULL sampled only in PEND; FULL changes during FILL have no effect.
- FULL rising in the same cycle WR would assert: WR stays 0, word held.
- SECTOR_DONE: high exactly one cycle, cycle n+2 for the final write at n+1; never asserted during reset or ABORT.
- Reset asserted mid-word or in PEND: all state returns to reset values asynchronously; partial data lost.

## Structure
- Shared package/header sdrd_pkg: SECTOR_BYTES, FAT_WORD_W (256), FAT_WORD_BYTES (32), WORDS_PER_SECTOR (16), state encoding for FILL/PEND.
- Single module; no sub-module. Byte insertion by indexed write into the 256-bit register at BCNT, not a shift chain.

## Test plan
- Reset then 32 bytes 0x00..0x1F back-to-back, FULL=0 -> one WR, OUTPUT = 0x1F1E..0100 (byte 0 in [7:0]), WR one cycle after 32nd accept, DIN_READY low for exactly that cycle.
- 512 bytes continuous, FULL=0 -> 16 WR pulses 33 cycles apart, single SECTOR_DONE pulse one cycle after 16th WR, WORD_CNT back to 0, SECTOR_CNT=1.
- FULL=1 held for 50 cycles at word completion -> WR stays 0, DIN_READY 0, OUTPUT stable; FULL drops -> WR one cycle, then DIN_READY returns 1.
- ABORT after 17 bytes, then 32 bytes 0xA0..0xBF -> one WR with OUTPUT containing only 0xA0..0xBF; WORD_CNT counts from 0.
- ABORT while in PEND with FULL=1 -> no WR ever for that word; SECTOR_CNT unchanged.
- Random DIN_VALID gaps and random FULL over 64 sectors -> scoreboard byte order exact, 1024 WR, SECTOR_CNT=64, no WR while FULL=1.
